// File: rtl/maze_pkg.sv
// Shared types for the maze solver.
//   state_t   : solver FSM states
//   dir_t     : per-cell pointer toward the goal recorded during the flood
//   rc_t      : row/column pair
//   idx_to_rc : split a row-major cell index into row and column
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLOOD,
    WALK,
    FAIL
  } state_t;

  typedef enum logic [1:0] {
    UP,
    LEFT,
    DOWN,
    RIGHT
  } dir_t;

  typedef struct packed {
    int unsigned row;
    int unsigned col;
  } rc_t;

  function automatic rc_t idx_to_rc(input int unsigned idx, input int unsigned dim);
    rc_t rc;
    rc.row = idx / dim;
    rc.col = idx % dim;
    return rc;
  endfunction

endpackage

// File: rtl/maze_wavefront.sv
// One combinational step of the flood fill from the goal.
//   maze         in   DIM*DIM  1 = wall, row-major
//   visited      in   DIM*DIM  cells already reached by the flood
//   next_visited out  DIM*DIM  visited plus cells reached this step
//   dir          out  DIM*DIM  pointer to the visited neighbour (up, left, down, right priority)
//   any_new      out  1        at least one cell was reached this step
module maze_wavefront
  import maze_pkg::*;
#(
  parameter int unsigned DIM = 15,
  localparam int unsigned N = DIM * DIM
) (
  input  logic [N-1:0] maze,
  input  logic [N-1:0] visited,
  output logic [N-1:0] next_visited,
  output dir_t         dir [N],
  output logic         any_new
);

  logic [N-1:0] up_ok, down_ok, left_ok, right_ok;
  logic [N-1:0] from_up, from_left, from_down, from_right;
  logic [N-1:0] newly;

  // Cells on the array edge have no neighbour on that side.
  always_comb begin
    up_ok    = '0;
    down_ok  = '0;
    left_ok  = '0;
    right_ok = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rc_t rc;
      rc          = idx_to_rc(i, DIM);
      up_ok[i]    = (rc.row != 0);
      down_ok[i]  = (rc.row != DIM - 1);
      left_ok[i]  = (rc.col != 0);
      right_ok[i] = (rc.col != DIM - 1);
    end
  end

  // Neighbour visited-ness gathered with whole-vector shifts: bit i of
  // (visited << DIM) is the cell one row above cell i, and so on.
  always_comb begin
    from_up      = (visited << DIM) & up_ok;
    from_down    = (visited >> DIM) & down_ok;
    from_left    = (visited << 1) & left_ok;
    from_right   = (visited >> 1) & right_ok;
    newly        = ~maze & ~visited & (from_up | from_left | from_down | from_right);
    next_visited = visited | newly;
    any_new      = |newly;
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      if (from_up[i]) begin
        dir[i] = UP;
      end else if (from_left[i]) begin
        dir[i] = LEFT;
      end else if (from_down[i]) begin
        dir[i] = DOWN;
      end else begin
        dir[i] = RIGHT;
      end
    end
  end

endmodule

// File: rtl/maze_path_solver.sv
// Serial-load maze solver: loads a DIM x DIM maze one bit per in_valid,
// floods from the goal (DIM-2,DIM-2) until the start (1,1) is reached, then
// streams the shortest path start->goal, or pulses maze_not_valid.
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   in_valid       in   1   maze bit valid
//   maze           in   1   cell value, row-major from (0,0); 1 = wall
//   out_valid      out  1   out_x/out_y carry a path coordinate
//   maze_not_valid out  1   one-cycle pulse when no path exists
//   out_x          out  CW  row of the path cell
//   out_y          out  CW  column of the path cell
module maze_path_solver
  import maze_pkg::*;
#(
  parameter int unsigned DIM = 15,
  localparam int unsigned CW = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          maze,
  output logic          out_valid,
  output logic          maze_not_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y
);

  localparam int unsigned N     = DIM * DIM;
  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned START = DIM + 1;
  localparam int unsigned GOAL  = (DIM - 2) * DIM + (DIM - 2);

  state_t         state, state_nxt;
  logic [N-1:0]   maze_q, visited_q, wf_next;
  dir_t           dir_q [N];
  dir_t           wf_dir [N];
  logic           wf_any_new;
  logic [IW-1:0]  cnt;
  logic [CW-1:0]  cur_r, cur_c;
  logic [IW-1:0]  cur_idx;
  logic           load_done, ends_blocked, at_goal;

  maze_wavefront #(.DIM(DIM)) u_wavefront (
    .maze         (maze_q),
    .visited      (visited_q),
    .next_visited (wf_next),
    .dir          (wf_dir),
    .any_new      (wf_any_new)
  );

  always_comb begin
    cur_idx      = IW'(cur_r * DIM + cur_c);
    load_done    = in_valid && (cnt == IW'(N - 1));
    ends_blocked = maze_q[START] || maze_q[GOAL];
    at_goal      = (cur_r == CW'(DIM - 2)) && (cur_c == CW'(DIM - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    out_valid      = 1'b0;
    maze_not_valid = 1'b0;
    out_x          = '0;
    out_y          = '0;
    case (state)
      IDLE:  if (in_valid) state_nxt = LOAD;
      LOAD:  if (load_done) state_nxt = FLOOD;
      FLOOD: begin
        if (ends_blocked) begin
          state_nxt = FAIL;
        end else if (wf_next[START]) begin
          state_nxt = WALK;
        end else if (!wf_any_new) begin
          state_nxt = FAIL;
        end
      end
      WALK: begin
        out_valid = 1'b1;
        out_x     = cur_r;
        out_y     = cur_c;
        if (at_goal) state_nxt = IDLE;
      end
      FAIL: begin
        maze_not_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze_q    <= '0;
      visited_q <= '0;
      cnt       <= '0;
      cur_r     <= '0;
      cur_c     <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        dir_q[i] <= UP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            maze_q[0] <= maze;
            cnt       <= IW'(1);
          end
        end
        LOAD: begin
          if (in_valid) begin
            maze_q[cnt] <= maze;
            cnt         <= cnt + IW'(1);
            if (load_done) begin
              // Seed the flood with the goal as the maze completes.
              cnt             <= '0;
              visited_q       <= '0;
              visited_q[GOAL] <= 1'b1;
            end
          end
        end
        FLOOD: begin
          if (!ends_blocked) begin
            visited_q <= wf_next;
            for (int unsigned i = 0; i < N; i++) begin
              if (wf_next[i] && !visited_q[i]) dir_q[i] <= wf_dir[i];
            end
            if (wf_next[START]) begin
              cur_r <= CW'(1);
              cur_c <= CW'(1);
            end
          end
        end
        WALK: begin
          if (!at_goal) begin
            case (dir_q[cur_idx])
              UP:    cur_r <= cur_r - CW'(1);
              LEFT:  cur_c <= cur_c - CW'(1);
              DOWN:  cur_r <= cur_r + CW'(1);
              RIGHT: cur_c <= cur_c + CW'(1);
              default: cur_r <= cur_r;
            endcase
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
